// File: rtl/spi_target_if.sv
// Avalon-MM register bus for spi_target.
//   master: drives chipselect/read/write/address/byteenable/writedata, receives readdata
//   slave : the reverse; readdata is combinational in the target
interface spi_target_if;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 3;
   localparam int unsigned BW = 4;

   logic          chipselect;
   logic          read;
   logic          write;
   logic [AW-1:0] address;
   logic [BW-1:0] byteenable;
   logic [DW-1:0] writedata;
   logic [DW-1:0] readdata;

   modport master (output chipselect, read, write, address, byteenable, writedata,
                   input  readdata);
   modport slave  (input  chipselect, read, write, address, byteenable, writedata,
                   output readdata);
endinterface

// File: rtl/spi_target.sv
// SPI target (slave) with Avalon-MM register access and TX/RX word FIFOs.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low
//   irq        : interrupt request (only driven when SPI_TARGET_IRQ_EN is defined)
//   bus        : spi_target_if.slave register port (DATA=0, STATUS=1, CONTROL=2)
//   sclk/cs_n/mosi : SPI inputs from the initiator, synchronized internally
//   miso       : serial data out, 0 when not selected
// Optional feature macro: SPI_TARGET_IRQ_EN enables CONTROL[8] IRQ_EN and irq.
module spi_target #(
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic        irq,
   spi_target_if.slave bus,
   input  logic        sclk,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso
);

   localparam int unsigned DW     = 32;
   localparam int unsigned AW     = $clog2(FIFO_DEPTH);
   localparam int unsigned CW     = AW + 1;
   localparam int unsigned NW     = 6;
   localparam int unsigned CTRL_W = 9;
   localparam int unsigned STAT_W = 7;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t state_q, state_d;

   logic [1:0]        sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic              sclk_prev_q, cs_prev_q;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DW-1:0]     tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
   logic [NW-1:0]     cnt_q, cnt_d;
   logic              tx_ov_q, tx_ov_d, rx_ov_q, rx_ov_d;
   logic              irq_q, irq_d, miso_q, miso_d;

   logic [DW-1:0]     tx_mem [FIFO_DEPTH];
   logic [DW-1:0]     rx_mem [FIFO_DEPTH];
   logic [AW-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [AW-1:0]     rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

   logic              unused_be_c;
   assign unused_be_c = ^bus.byteenable;

   // Synchronized SPI inputs and edge detection
   logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall;
   assign sclk_s    = sclk_sync_q[1];
   assign cs_s      = cs_sync_q[1];
   assign mosi_s    = mosi_sync_q[1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;

   // Control fields
   logic [4:0] wlen;
   logic       cpol, cpha, en;
   assign wlen = ctrl_q[4:0];
   assign cpol = ctrl_q[5];
   assign cpha = ctrl_q[6];
   assign en   = ctrl_q[7];

   // Sample/shift edge selection from CPOL/CPHA
   logic lead_edge, trail_edge, sample_edge, shift_edge;
   assign lead_edge   = cpol ? sclk_fall : sclk_rise;
   assign trail_edge  = cpol ? sclk_rise : sclk_fall;
   assign sample_edge = cpha ? trail_edge : lead_edge;
   assign shift_edge  = cpha ? lead_edge : trail_edge;

   // Register decode
   logic wr_data, wr_stat, wr_ctrl, rd_data;
   assign wr_data = bus.chipselect & bus.write & (bus.address == 3'd0);
   assign wr_stat = bus.chipselect & bus.write & (bus.address == 3'd1);
   assign wr_ctrl = bus.chipselect & bus.write & (bus.address == 3'd2);
   assign rd_data = bus.chipselect & bus.read  & (bus.address == 3'd0);

   logic tx_empty, tx_full, rx_empty, rx_full;
   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));

   logic [DW-1:0] rx_word_c;
   assign rx_word_c = {rx_sh_q[DW-2:0], mosi_s};

   // FSM next state and shift datapath
   logic tx_pop_c, rx_push_c, load_c;
   always_comb begin
      state_d   = state_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      cnt_d     = cnt_q;
      tx_pop_c  = 1'b0;
      rx_push_c = 1'b0;
      load_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && cs_fall) begin
               state_d = ACTIVE;
               load_c  = 1'b1;
            end
         end
         ACTIVE: begin
            if (!en || cs_s) begin
               state_d = IDLE;
            end else if (sample_edge) begin
               rx_sh_d = rx_word_c;
               if (cnt_q == NW'(1)) begin
                  rx_push_c = 1'b1;
                  load_c    = 1'b1;
               end else begin
                  cnt_d = cnt_q - NW'(1);
               end
            end else if (shift_edge && (cnt_q != NW'(wlen) + NW'(1))) begin
               // No shift before the first sample of a word, so CPHA=1 keeps the MSB
               tx_sh_d = tx_sh_q << 1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Word (re)load: TX head or zeros, rx cleared so short words zero-extend
      if (load_c) begin
         tx_pop_c = ~tx_empty;
         tx_sh_d  = tx_empty ? '0 : tx_mem[tx_rp_q];
         rx_sh_d  = '0;
         cnt_d    = NW'(wlen) + NW'(1);
      end
   end

   // FIFO next state; a full FIFO still accepts when popping in the same cycle
   logic tx_push_c, tx_drop_c, rx_pop_c, rx_wr_c, rx_drop_c;
   always_comb begin
      tx_push_c = wr_data & (~tx_full | tx_pop_c);
      tx_drop_c = wr_data & tx_full & ~tx_pop_c;
      rx_pop_c  = rd_data & ~rx_empty;
      rx_wr_c   = rx_push_c & (~rx_full | rx_pop_c);
      rx_drop_c = rx_push_c & rx_full & ~rx_pop_c;
      tx_wp_d   = tx_push_c ? tx_wp_q + AW'(1) : tx_wp_q;
      tx_rp_d   = tx_pop_c  ? tx_rp_q + AW'(1) : tx_rp_q;
      tx_cnt_d  = tx_cnt_q + CW'(tx_push_c) - CW'(tx_pop_c);
      rx_wp_d   = rx_wr_c   ? rx_wp_q + AW'(1) : rx_wp_q;
      rx_rp_d   = rx_pop_c  ? rx_rp_q + AW'(1) : rx_rp_q;
      rx_cnt_d  = rx_cnt_q + CW'(rx_wr_c) - CW'(rx_pop_c);
      // Disable flushes both FIFOs
      if (!en) begin
         tx_wp_d  = '0;
         tx_rp_d  = '0;
         tx_cnt_d = '0;
         rx_wp_d  = '0;
         rx_rp_d  = '0;
         rx_cnt_d = '0;
      end
   end

   // Control, overflow flags (set wins over W1C), irq and miso
   always_comb begin
      ctrl_d = ctrl_q;
      if (wr_ctrl) begin
`ifdef SPI_TARGET_IRQ_EN
         ctrl_d = bus.writedata[CTRL_W-1:0];
`else
         ctrl_d = {1'b0, bus.writedata[CTRL_W-2:0]};
`endif
      end
      tx_ov_d = tx_drop_c | (tx_ov_q & ~(wr_stat & bus.writedata[2]));
      rx_ov_d = rx_drop_c | (rx_ov_q & ~(wr_stat & bus.writedata[5]));
`ifdef SPI_TARGET_IRQ_EN
      irq_d = ctrl_d[8] & ((rx_cnt_d != '0) | rx_ov_d | tx_ov_d);
`else
      irq_d = 1'b0;
`endif
      miso_d = (state_d == ACTIVE) ? tx_sh_d[wlen] : 1'b0;
   end

   // Combinational read mux
   logic [STAT_W-1:0] status_c;
   logic [DW-1:0]     rdata_c;
   assign status_c = {(state_q == ACTIVE), rx_ov_q, rx_full, rx_empty, tx_ov_q, tx_full, tx_empty};
   always_comb begin
      rdata_c = '0;
      if (reset && bus.chipselect && bus.read) begin
         case (bus.address)
            3'd0:    rdata_c = rx_empty ? '0 : rx_mem[rx_rp_q];
            3'd1:    rdata_c = DW'(status_c);
            3'd2:    rdata_c = DW'(ctrl_q);
            default: rdata_c = '0;
         endcase
      end
   end
   assign bus.readdata = rdata_c;
   assign irq          = irq_q;
   assign miso         = miso_q;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_sync_q <= 2'b00;
         cs_sync_q   <= 2'b11;
         mosi_sync_q <= 2'b00;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         ctrl_q      <= '0;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         cnt_q       <= '0;
         tx_ov_q     <= 1'b0;
         rx_ov_q     <= 1'b0;
         irq_q       <= 1'b0;
         miso_q      <= 1'b0;
         tx_wp_q     <= '0;
         tx_rp_q     <= '0;
         tx_cnt_q    <= '0;
         rx_wp_q     <= '0;
         rx_rp_q     <= '0;
         rx_cnt_q    <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], sclk};
         cs_sync_q   <= {cs_sync_q[0], cs_n};
         mosi_sync_q <= {mosi_sync_q[0], mosi};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
         ctrl_q      <= ctrl_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         cnt_q       <= cnt_d;
         tx_ov_q     <= tx_ov_d;
         rx_ov_q     <= rx_ov_d;
         irq_q       <= irq_d;
         miso_q      <= miso_d;
         tx_wp_q     <= tx_wp_d;
         tx_rp_q     <= tx_rp_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_wp_q     <= rx_wp_d;
         rx_rp_q     <= rx_rp_d;
         rx_cnt_q    <= rx_cnt_d;
      end
   end

   // FIFO storage (contents need no reset; pointers define validity)
   always_ff @(posedge clk) begin
      if (tx_push_c) tx_mem[tx_wp_q] <= bus.writedata;
      if (rx_wr_c)   rx_mem[rx_wp_q] <= rx_word_c;
   end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: register vector table plus SPI initiator sequences.
module tb_spi_target;

   localparam int unsigned HALF = 8;
`ifdef SPI_TARGET_IRQ_EN
   localparam logic [31:0] CTRL_ALL = 32'h0000_01FF;
   localparam logic        IRQ_EXP  = 1'b1;
`else
   localparam logic [31:0] CTRL_ALL = 32'h0000_00FF;
   localparam logic        IRQ_EXP  = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, irq, sclk, cs_n, mosi, miso;
   int   n_chk = 0;
   int   n_fail = 0;

   spi_target_if bus_if ();

   spi_target #(.FIFO_DEPTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .irq   (irq),
      .bus   (bus_if),
      .sclk  (sclk),
      .cs_n  (cs_n),
      .mosi  (mosi),
      .miso  (miso)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_if.chipselect = 1'b1;
      bus_if.write      = 1'b1;
      bus_if.address    = a;
      bus_if.writedata  = d;
      @(negedge clk);
      bus_if.chipselect = 1'b0;
      bus_if.write      = 1'b0;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_if.chipselect = 1'b1;
      bus_if.read       = 1'b1;
      bus_if.address    = a;
      #1 d = bus_if.readdata;
      @(negedge clk);
      bus_if.chipselect = 1'b0;
      bus_if.read       = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_rd(a, d);
      check(name, d, exp);
   endtask

   task automatic half_bit();
      repeat (HALF) @(negedge clk);
   endtask

   // Initiator: shifts nbits of 'out' MSB first and captures miso
   task automatic spi_xfer(input bit cpol, input bit cpha, input int nbits,
                           input logic [31:0] out, output logic [31:0] got);
      got = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         if (!cpha) begin
            mosi = out[i];
            half_bit();
            got[i] = miso;
            sclk = ~cpol;
            half_bit();
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = out[i];
            half_bit();
            got[i] = miso;
            sclk = cpol;
            half_bit();
         end
      end
      half_bit();
   endtask

   initial begin
      logic [31:0] g0, g1;

      tbl[0]  = '{1'b0, 3'd1, 32'h0,         32'h0000_0009};
      tbl[1]  = '{1'b0, 3'd2, 32'h0,         32'h0};
      tbl[2]  = '{1'b0, 3'd0, 32'h0,         32'h0};
      tbl[3]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0};
      tbl[4]  = '{1'b0, 3'd2, 32'h0,         CTRL_ALL};
      tbl[5]  = '{1'b1, 3'd3, 32'h1234,      32'h0};
      tbl[6]  = '{1'b0, 3'd3, 32'h0,         32'h0};
      tbl[7]  = '{1'b0, 3'd7, 32'h0,         32'h0};
      tbl[8]  = '{1'b1, 3'd2, 32'h0,         32'h0};
      tbl[9]  = '{1'b1, 3'd0, 32'h55,        32'h0};
      tbl[10] = '{1'b0, 3'd1, 32'h0,         32'h0000_0009};

      reset = 1'b0;
      sclk  = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      bus_if.chipselect = 1'b0;
      bus_if.read       = 1'b0;
      bus_if.write      = 1'b0;
      bus_if.address    = '0;
      bus_if.byteenable = 4'hF;
      bus_if.writedata  = '0;
      repeat (3) @(negedge clk);
      check("reset_irq", {31'b0, irq}, 32'h0);
      check("reset_miso", {31'b0, miso}, 32'h0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Register map vectors
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].wr) bus_wr(tbl[i].addr, tbl[i].data);
         else           rd_chk($sformatf("reg_vec%0d", i), tbl[i].addr, tbl[i].exp);
      end

      // Mode 0, 8-bit: TX 0xA5, initiator sends 0x3C
      bus_wr(3'd2, 32'h87);
      bus_wr(3'd0, 32'hA5);
      rd_chk("m0_stat_pre", 3'd1, 32'h08);
      sclk = 1'b0;
      cs_n = 1'b0;
      half_bit();
      rd_chk("m0_stat_busy", 3'd1, 32'h49);
      spi_xfer(1'b0, 1'b0, 8, 32'h3C, g0);
      check("m0_miso", g0, 32'hA5);
      rd_chk("m0_data", 3'd0, 32'h3C);
      rd_chk("m0_stat_post", 3'd1, 32'h49);
      cs_n = 1'b1;
      half_bit();
      rd_chk("m0_stat_idle", 3'd1, 32'h09);

      // Partial word: cs_n raised after 5 of 8 bits
      bus_wr(3'd0, 32'hFF);
      cs_n = 1'b0;
      half_bit();
      spi_xfer(1'b0, 1'b0, 5, 32'h15, g0);
      check("part_miso_bits", g0, 32'h1F);
      cs_n = 1'b1;
      half_bit();
      check("part_miso_idle", {31'b0, miso}, 32'h0);
      rd_chk("part_stat", 3'd1, 32'h09);

      // Mode 3, 32-bit, two back-to-back words
      bus_wr(3'd2, 32'hFF);
      sclk = 1'b1;
      half_bit();
      bus_wr(3'd0, 32'hDEAD_BEEF);
      bus_wr(3'd0, 32'h1234_5678);
      cs_n = 1'b0;
      half_bit();
      spi_xfer(1'b1, 1'b1, 32, 32'hCAFE_F00D, g0);
      spi_xfer(1'b1, 1'b1, 32, 32'h0F1E_2D3C, g1);
      check("m3_miso0", g0, 32'hDEAD_BEEF);
      check("m3_miso1", g1, 32'h1234_5678);
      rd_chk("m3_stat", 3'd1, 32'h41);
      rd_chk("m3_data0", 3'd0, 32'hCAFE_F00D);
      rd_chk("m3_data1", 3'd0, 32'h0F1E_2D3C);
      cs_n = 1'b1;
      half_bit();
      rd_chk("m3_stat_idle", 3'd1, 32'h09);

      // 17 words with empty TX: RX fills and overflows
      bus_wr(3'd2, 32'h87);
      sclk = 1'b0;
      half_bit();
      cs_n = 1'b0;
      half_bit();
      for (int i = 0; i < 17; i++) begin
         spi_xfer(1'b0, 1'b0, 8, 32'(i + 1), g0);
         if (i == 0) check("txempty_miso", g0, 32'h0);
      end
      cs_n = 1'b1;
      half_bit();
      rd_chk("rxov_stat", 3'd1, 32'h31);
      bus_wr(3'd1, 32'h20);
      rd_chk("rxov_w1c", 3'd1, 32'h11);
      for (int i = 0; i < 16; i++) rd_chk($sformatf("rx_drain%0d", i), 3'd0, 32'(i + 1));
      rd_chk("rx_drained", 3'd1, 32'h09);

      // 17 DATA writes: TX overflow, W1C, then flush by disable
      for (int i = 0; i < 17; i++) bus_wr(3'd0, 32'(i));
      rd_chk("txov_stat", 3'd1, 32'h0E);
      bus_wr(3'd1, 32'h04);
      rd_chk("txov_w1c", 3'd1, 32'h0A);
      bus_wr(3'd2, 32'h0);
      rd_chk("flush_stat", 3'd1, 32'h09);

      // irq on received word, then reset mid-word
      bus_wr(3'd2, 32'h187);
      check("irq_idle", {31'b0, irq}, 32'h0);
      bus_wr(3'd0, 32'hFF);
      bus_wr(3'd0, 32'hFF);
      cs_n = 1'b0;
      half_bit();
      spi_xfer(1'b0, 1'b0, 8, 32'h81, g0);
      check("irq_word", {31'b0, irq}, {31'b0, IRQ_EXP});
      spi_xfer(1'b0, 1'b0, 4, 32'h0, g0);
      check("midword_miso", {31'b0, miso}, 32'h1);
      @(negedge clk);
      reset = 1'b0;
      bus_if.chipselect = 1'b1;
      bus_if.read       = 1'b1;
      bus_if.address    = 3'd1;
      #1;
      check("rst_miso", {31'b0, miso}, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      check("rst_readdata", bus_if.readdata, 32'h0);
      repeat (2) @(negedge clk);
      bus_if.chipselect = 1'b0;
      bus_if.read       = 1'b0;
      cs_n = 1'b1;
      sclk = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      half_bit();
      rd_chk("rst_stat", 3'd1, 32'h09);
      rd_chk("rst_ctrl", 3'd2, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning the number of 32-bit words in each of the TX and RX FIFOs (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port irq  output  1  interrupt request.
REQ-005 SHALL have ports chipselect, read, write  input  1 each  Avalon-MM control.
REQ-006 SHALL have port address  input  3  register select.
REQ-007 SHALL have port byteenable  input  4  accepted and ignored.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port readdata  output  32  combinational read data; 0 when not (read && chipselect).
REQ-010 SHALL have port sclk  input  1  SPI clock from the initiator.
REQ-011 SHALL have port cs_n  input  1  SPI select, active-low.
REQ-012 SHALL have port mosi  input  1  serial data in.
REQ-013 SHALL have port miso  output  1  serial data out, driven 0 when not selected.

Function
REQ-014 SHALL map registers as follows: 0 DATA; 1 STATUS; 2 CONTROL; 3-7 read 0, writes ignored.
REQ-015 SHALL pop the RX FIFO head on a DATA read, one pop per clk cycle with read && chipselect; an empty read returns 0 and does not pop.
REQ-016 SHALL push writedata to the TX FIFO on a DATA write; a write when full is dropped and sets TX_OV.
REQ-017 SHALL define STATUS as [0]TX_FE [1]TX_FF [2]TX_OV [3]RX_FE [4]RX_FF [5]RX_OV [6]BUSY, with other bits 0; writing 1 to bit 2 or bit 5 clears that bit.
REQ-018 SHALL define CONTROL as [4:0]WLEN (word = WLEN+1 bits) [5]CPOL [6]CPHA [7]ENABLE [8]IRQ_EN; all bits read back as written.
REQ-019 SHALL pass sclk, cs_n and mosi through 2-flop synchronizers and detect edges on the synchronized sclk; sclk SHALL be at most clk/8.
REQ-020 SHALL use a two-state FSM, IDLE and ACTIVE.
REQ-021 SHALL move IDLE->ACTIVE when the synchronized cs_n falls with ENABLE=1; on that transition it pops the TX head into the shift register (0 if empty, no pop), loads the bit count with WLEN+1, and sets BUSY.
REQ-022 SHALL sample on the leading sclk edge when CPHA=0 and on the trailing edge when CPHA=1; leading means rising when CPOL=0.
REQ-023 SHALL transfer MSB first; with CPHA=0, miso presents bit WLEN from ACTIVE entry.
REQ-024 SHALL, after WLEN+1 samples, push the received word zero-extended to the RX FIFO; if RX is full the word is dropped and RX_OV is set.
REQ-025 SHALL then reload TX and the count as in REQ-021 and remain ACTIVE while cs_n is low.
REQ-026 SHALL, when cs_n rises while ACTIVE, discard any partial word, go to IDLE, clear BUSY and drive miso 0.
REQ-027 SHALL, when ENABLE=0, force IDLE and flush both FIFOs; the OV flags hold.
REQ-028 SHALL, on a same-cycle push and pop on one FIFO, perform both, leaving occupancy unchanged.
REQ-029 SHALL set TX_FF/RX_FF at FIFO_DEPTH entries and wrap pointers modulo FIFO_DEPTH.
REQ-030 SHALL, on a same-cycle set and W1C of an OV flag, give set priority.

Reset
REQ-031 SHALL, on reset low, immediately clear CONTROL, the FIFOs, the OV flags, the FSM (IDLE), the shift register, the counters and the synchronizers (sclk sync to 0, cs_n sync to 1), with irq=0, miso=0 and readdata=0; a reset mid-word discards the word.

Configuration
REQ-032 SHALL, with SPI_TARGET_IRQ_EN defined, drive irq = IRQ_EN && (!RX_FE || RX_OV || TX_OV).
REQ-033 SHALL, without SPI_TARGET_IRQ_EN, tie irq to 0, make CONTROL[8] read 0, and ignore writes to CONTROL[8].

Verification
REQ-034 SHALL cover: mode 0, WLEN=7, TX holds 0xA5, initiator sends 0x3C -> miso shifts 10100101 and DATA read returns 0x0000003C.
REQ-035 SHALL cover: mode 3, WLEN=31, two back-to-back words with cs_n held low -> both received in order and TX popped twice.
REQ-036 SHALL cover: cs_n raised after 5 of 8 bits -> RX_FE stays 1, BUSY=0 and miso=0.
REQ-037 SHALL cover: 17 words received with no DATA reads (depth 16) -> RX_FF=1, RX_OV=1; writing STATUS=0x20 clears RX_OV.
REQ-038 SHALL cover: TX empty at cs_n fall -> miso all zeros and TX_OV unchanged; 17 DATA writes -> TX_OV=1.
REQ-039 SHALL cover: reset asserted mid-word -> all outputs 0 within the same cycle; with IRQ_EN=1 and a word received -> irq=1 when SPI_TARGET_IRQ_EN is defined, otherwise 0.
